uart_tx_framer: RTL
===================

// Module: uart_tx_framer
// PURPOSE
//  Multi-channel successor to the single-source UART TX bridge. Arbitrates NUM_CH upstream message
//  sources round-robin, serialises each accepted request as a framed byte stream and feeds it to the
//  low-level UART transmitter. Frame: START_BYTE, channel id, header, optional length byte,
//  runtime-length payload, optional XOR checksum. Sits between control logic and uart_tx (FTDI link).
// PARAMETERS
//  NUM_CH       2     number of upstream channels (1..16)
//  HEADER_SIZE  32    header bits per frame, multiple of 8
//  MESSAGE_SIZE 512   max payload bits, multiple of 8; MAX_LEN = MESSAGE_SIZE/8 bytes
//  START_BYTE   8'hBB frame delimiter byte
//  LEN_BYTE_EN  1     1: send payload length byte after header (needs MAX_LEN <= 255)
//  CSUM_EN      1     1: append XOR checksum byte
//  LEN_W        $clog2(MESSAGE_SIZE/8+1)  width of each length field (derived)
// PORTS
//  clk_in          in   1                    system clock
//  rst_n_in        in   1                    asynchronous active-low reset
//  ch_valid_in     in   NUM_CH               per-channel request valid
//  ch_ready_out    out  NUM_CH               per-channel accept (one-hot or zero)
//  ch_header_in    in   NUM_CH*HEADER_SIZE   channel i header at [i*HEADER_SIZE +: HEADER_SIZE]
//  ch_message_in   in   NUM_CH*MESSAGE_SIZE  channel i payload, byte 0 at LSBs
//  ch_len_in       in   NUM_CH*LEN_W         channel i payload length in bytes; 0 = header-only frame
//  ll_byte_out     out  8                    byte to transmitter
//  ll_valid_out    out  1                    ll_byte_out valid
//  ll_ready_in     in   1                    transmitter accepts byte when ll_valid_out&ll_ready_in
//  busy_out        out  1                    high while a frame is in flight (state != IDLE)
//  active_ch_out   out  $clog2(NUM_CH)|1     channel of current/last frame
//  frame_done_out  out  1                    1-cycle pulse when the last byte of a frame transfers
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE, ll_valid_out=0, ll_byte_out=0, busy_out=0,
//    active_ch_out=0, frame_done_out=0, rr pointer=0. ch_ready_out is 0 while rst_n_in is low.
//  - Reset mid-frame: frame abandoned immediately; no partial resume and no retransmit.
//  - ch_ready_out is combinational. In IDLE, grant = first i with ch_valid_in[i], searching
//    rr_ptr, rr_ptr+1, ... with wrap; ch_ready_out = onehot(grant). It is 0 outside IDLE.
//    Accept = ch_valid_in[i]&ch_ready_out[i]. On accept: header, payload and len are captured into
//    buffers (upstream may drop data next cycle), rr_ptr <= grant+1 mod NUM_CH, active_ch_out <= grant.
//  - Length: captured len > MAX_LEN is clamped to MAX_LEN.
//  - States: IDLE -> START -> CHID -> HDR -> [LEN] -> [PAY] -> [CSUM] -> IDLE.
//    LEN is skipped if !LEN_BYTE_EN. PAY is skipped if len==0. CSUM is skipped if !CSUM_EN.
//  - Byte values: START=START_BYTE; CHID={zero-pad, grant}; HDR sends HEADER_SIZE/8 bytes, LSB byte
//    first; LEN=len[7:0]; PAY sends bytes 0..len-1; CSUM=XOR of every byte from CHID through the last
//    PAY (START excluded).
//  - Handshake: ll_valid_out rises the cycle after accept, with ll_byte_out=START_BYTE. ll_byte_out is
//    held stable while ll_valid_out&!ll_ready_in. On a transfer, the next byte is loaded in the same
//    edge and ll_valid_out stays 1 (zero bubble). With ll_ready_in tied high, a frame of B bytes
//    occupies exactly B consecutive cycles.
//  - On the final transfer: ll_valid_out<=0, frame_done_out<=1 for one cycle, state<=IDLE.
//    A new grant is possible in the following cycle (min 1 idle cycle between frames).
//  - Arithmetic: byte indices wrap-free; the index counter width covers max(HEADER_SIZE,MESSAGE_SIZE)/8.
//    Checksum is an 8-bit running XOR, cleared on accept.
//  - Inputs of non-granted channels are ignored; changes on ch_*_in mid-frame have no effect.
// TESTING
//  1 ch0 hdr=32'h44332211 len=0, ll_ready=1 -> bytes BB 00 11 22 33 44 00 44 on 8 consecutive
//    cycles, frame_done pulse on the 8th.
//  2 ch1 hdr=0 len=3 payload 0x030201 -> BB 01 00 00 00 00 03 01 02 03, csum 01^03^01^02^03 = 02.
//  3 Scenario 2 with ll_ready_in toggling 1010.. and random stalls -> identical byte sequence, and
//    ll_byte_out stable during every stall.
//  4 ch0 and ch1 valid together, held for 3 frames each -> grants alternate 0,1,0,1,0,1; each
//    ch_ready_out is a single-cycle pulse.
//  5 len=200 with MESSAGE_SIZE=512 -> LEN byte 0x40; exactly 64 payload bytes sent.
//  6 rst_n_in low during payload byte 5 -> ll_valid_out=0 without waiting for a clock edge;
//    after release, a new request yields a clean frame starting with BB.

Source files
------------

// File: rtl/uart_tx_framer_if.sv
// Handshake bundle for uart_tx_framer: per-channel upstream requests plus the byte link
// toward uart_tx. The environment side uses master, the framer uses slave.
interface uart_tx_framer_if #(
    parameter int NUM_CH       = 2,
    parameter int HEADER_SIZE  = 32,
    parameter int MESSAGE_SIZE = 512
);
    localparam int LEN_W = $clog2(MESSAGE_SIZE / 8 + 1);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]              ch_valid_in;
    logic [NUM_CH-1:0]              ch_ready_out;
    logic [NUM_CH*HEADER_SIZE-1:0]  ch_header_in;
    logic [NUM_CH*MESSAGE_SIZE-1:0] ch_message_in;
    logic [NUM_CH*LEN_W-1:0]        ch_len_in;
    logic [7:0]                     ll_byte_out;
    logic                           ll_valid_out;
    logic                           ll_ready_in;
    logic                           busy_out;
    logic [CH_W-1:0]                active_ch_out;
    logic                           frame_done_out;

    modport master (
        output ch_valid_in, ch_header_in, ch_message_in, ch_len_in, ll_ready_in,
        input  ch_ready_out, ll_byte_out, ll_valid_out, busy_out, active_ch_out, frame_done_out
    );

    modport slave (
        input  ch_valid_in, ch_header_in, ch_message_in, ch_len_in, ll_ready_in,
        output ch_ready_out, ll_byte_out, ll_valid_out, busy_out, active_ch_out, frame_done_out
    );
endinterface

// File: rtl/uart_tx_framer.sv
// Round-robin multi-channel framer: START, channel id, header, optional length, payload and
// optional XOR checksum, streamed byte-by-byte to uart_tx with a zero-bubble valid/ready link.
module uart_tx_framer #(
    parameter int         NUM_CH       = 2,
    parameter int         HEADER_SIZE  = 32,
    parameter int         MESSAGE_SIZE = 512,
    parameter logic [7:0] START_BYTE   = 8'hBB,
    parameter bit         LEN_BYTE_EN  = 1'b1,
    parameter bit         CSUM_EN      = 1'b1
) (
    input logic             clk_in,
    input logic             rst_n_in,
    uart_tx_framer_if.slave bus
);
    localparam int MAX_LEN   = MESSAGE_SIZE / 8;
    localparam int HDR_BYTES = HEADER_SIZE / 8;
    localparam int LEN_W     = $clog2(MAX_LEN + 1);
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_MAX   = (HDR_BYTES > MAX_LEN) ? HDR_BYTES : MAX_LEN;
    localparam int IDX_W     = $clog2(IDX_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_CHID, S_HDR, S_LEN, S_PAY, S_CSUM
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CH_W-1:0]         rr_ptr;
    logic [CH_W-1:0]         rr_next;
    logic [CH_W-1:0]         grant;
    logic [CH_W-1:0]         active_ch;
    logic                    found;
    logic                    accept;
    logic                    valid;
    logic                    xfer;
    logic                    frame_done;
    logic [IDX_W-1:0]        idx;
    logic [HEADER_SIZE-1:0]  hdr_buf;
    logic [HEADER_SIZE-1:0]  sel_hdr;
    logic [MESSAGE_SIZE-1:0] msg_buf;
    logic [MESSAGE_SIZE-1:0] sel_msg;
    logic [LEN_W-1:0]        len_buf;
    logic [LEN_W-1:0]        sel_len;
    logic [7:0]              csum;
    logic [7:0]              cur_byte;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    endfunction

    function automatic state_t after_len(input logic [LEN_W-1:0] len);
        if (len != '0) return S_PAY;
        return CSUM_EN ? S_CSUM : S_IDLE;
    endfunction

    // Rotate requests so bit 0 is rr_ptr; the lowest set bit is the winner.
    always_comb begin
        logic [NUM_CH-1:0] rot;
        int                g;
        rot   = NUM_CH'({bus.ch_valid_in, bus.ch_valid_in} >> rr_ptr);
        found = 1'b0;
        g     = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                g     = int'(rr_ptr) + k;
            end
        end
        if (g >= NUM_CH) g = g - NUM_CH;
        grant   = CH_W'(g);
        rr_next = (g == NUM_CH - 1) ? '0 : CH_W'(g + 1);
    end

    always_comb begin
        sel_hdr = '0;
        sel_msg = '0;
        sel_len = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == CH_W'(i)) begin
                sel_hdr = bus.ch_header_in[i*HEADER_SIZE +: HEADER_SIZE];
                sel_msg = bus.ch_message_in[i*MESSAGE_SIZE +: MESSAGE_SIZE];
                sel_len = bus.ch_len_in[i*LEN_W +: LEN_W];
            end
        end
    end

    assign accept           = (state == S_IDLE) && found && rst_n_in;
    assign bus.ch_ready_out = accept ? (NUM_CH'(1) << grant) : '0;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= S_IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_START;
            S_START: if (xfer) state_next = S_CHID;
            S_CHID:  if (xfer) state_next = S_HDR;
            S_HDR:   if (xfer && idx == IDX_W'(HDR_BYTES - 1))
                         state_next = LEN_BYTE_EN ? S_LEN : after_len(len_buf);
            S_LEN:   if (xfer) state_next = after_len(len_buf);
            S_PAY:   if (xfer && idx == IDX_W'(len_buf) - 1'b1)
                         state_next = CSUM_EN ? S_CSUM : S_IDLE;
            S_CSUM:  if (xfer) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // The presented byte is a pure function of state and buffers, so it holds through stalls.
    always_comb begin
        cur_byte = 8'h00;
        case (state)
            S_START: cur_byte = START_BYTE;
            S_CHID:  cur_byte = 8'(active_ch);
            S_HDR:   cur_byte = hdr_buf[7:0];
            S_LEN:   cur_byte = 8'(len_buf);
            S_PAY:   cur_byte = msg_buf[7:0];
            S_CSUM:  cur_byte = csum;
            default: cur_byte = 8'h00;
        endcase
    end

    assign valid              = (state != S_IDLE);
    assign xfer               = valid && bus.ll_ready_in;
    assign bus.ll_byte_out    = cur_byte;
    assign bus.ll_valid_out   = valid;
    assign bus.busy_out       = valid;
    assign bus.active_ch_out  = active_ch;
    assign bus.frame_done_out = frame_done;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_ptr     <= '0;
            active_ch  <= '0;
            frame_done <= 1'b0;
            idx        <= '0;
        end else begin
            frame_done <= xfer && (state_next == S_IDLE);
            if (accept) begin
                rr_ptr    <= rr_next;
                active_ch <= grant;
                idx       <= '0;
            end else if (xfer) begin
                idx <= (state_next == state) ? idx + 1'b1 : '0;
            end
        end
    end

    // Header and payload drain as shift registers; the low byte is always the next to send.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            hdr_buf <= sel_hdr;
            msg_buf <= sel_msg;
            len_buf <= clamp_len(sel_len);
            csum    <= 8'h00;
        end else if (xfer) begin
            if (state == S_HDR) hdr_buf <= hdr_buf >> 8;
            if (state == S_PAY) msg_buf <= msg_buf >> 8;
            if (state inside {S_CHID, S_HDR, S_LEN, S_PAY}) csum <= csum ^ cur_byte;
        end
    end
endmodule
